// File: rtl/meta_arb_pkg.sv
// -----------------------------------------------------------------------------
// meta_arb_pkg
// Shared constants and types for the cache metadata write arbiter:
//   - default field widths for set index, way enable and tag
//   - upper bound on the number of request inputs
//   - arbitration policy encodings
//   - packed metadata request record at the default widths
// -----------------------------------------------------------------------------
package meta_arb_pkg;

  localparam int DEF_IDX_W = 6;
  localparam int DEF_WAYS  = 8;
  localparam int DEF_TAG_W = 20;
  localparam int N_IN_MAX  = 8;

  localparam int POLICY_FIXED = 0;  // input 0 always has highest priority
  localparam int POLICY_RR    = 1;  // priority rotates past the last winner

  typedef struct packed {
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_WAYS-1:0]  way_en;
    logic [DEF_TAG_W-1:0] tag;
  } meta_req_t;

endpackage

// File: rtl/meta_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// meta_write_arbiter_if
// Bundle of the arbiter's request-side and tag-array-side signals.
//   in_valid/in_ready    per-input handshake (N_IN bits each)
//   in_idx/in_way_en/in_tag  packed per-input payload, input i at [i*W +: W]
//   out_valid/out_ready  output handshake toward the tag array write port
//   out_idx/out_way_en/out_tag/out_src  registered request and its source
// Modports: master = request sources plus downstream sink, slave = arbiter.
// -----------------------------------------------------------------------------
interface meta_write_arbiter_if
  import meta_arb_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int IDX_W = DEF_IDX_W,
  parameter int WAYS  = DEF_WAYS,
  parameter int TAG_W = DEF_TAG_W
);
  localparam int SRC_W = $clog2(N_IN);

  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic [N_IN*IDX_W-1:0] in_idx;
  logic [N_IN*WAYS-1:0]  in_way_en;
  logic [N_IN*TAG_W-1:0] in_tag;

  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_W-1:0]      out_idx;
  logic [WAYS-1:0]       out_way_en;
  logic [TAG_W-1:0]      out_tag;
  logic [SRC_W-1:0]      out_src;

  modport master (
    output in_valid, in_idx, in_way_en, in_tag, out_ready,
    input  in_ready, out_valid, out_idx, out_way_en, out_tag, out_src
  );

  modport slave (
    input  in_valid, in_idx, in_way_en, in_tag, out_ready,
    output in_ready, out_valid, out_idx, out_way_en, out_tag, out_src
  );

endinterface

// File: rtl/rr_prio_select.sv
// -----------------------------------------------------------------------------
// rr_prio_select
// Combinational rotating-priority selector.
//   req        in   N   request bits
//   start      in   SW  index with highest priority this cycle (must be < N)
//   grant      out  N   one-hot grant, all zero when req is zero
//   grant_idx  out  SW  binary index of the granted bit
// The request vector is doubled so the search can run past the top bit and
// wrap; bits below start are masked off and the lowest remaining set bit wins.
// -----------------------------------------------------------------------------
module rr_prio_select #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  localparam logic [2*N-1:0] ONE = 1;

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // NOTE: every signal written in always_comb gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    mask = '0;
    for (int i = 0; i < 2*N; i++) begin
      mask[i] = (i >= int'(start));
    end
    dbl    = {req, req};
    masked = dbl & mask;
    // x & -x isolates the lowest set bit.
    first  = masked & (~masked + ONE);
    // The winner lies in [start, start+N-1]; folding the halves makes it one-hot.
    grant  = first[N-1:0] | first[2*N-1:N];

    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = grant_idx | SW'(i);
    end
  end

endmodule

// File: rtl/meta_write_arbiter.sv
// -----------------------------------------------------------------------------
// meta_write_arbiter
// N-input arbiter for cache metadata write requests with a one-entry output
// register. Selects one valid input per cycle (fixed priority or round-robin)
// and loads it whenever the register is empty or draining in the same cycle.
//   clock  in  sole clock, rising edge
//   reset  in  synchronous, active-high; discards any held request
//   bus    slave modport of meta_write_arbiter_if (request inputs, output
//          register contents and handshakes)
// -----------------------------------------------------------------------------
module meta_write_arbiter
  import meta_arb_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int IDX_W = DEF_IDX_W,
  parameter int WAYS  = DEF_WAYS,
  parameter int TAG_W = DEF_TAG_W,
  parameter int RR    = POLICY_FIXED
) (
  input logic                 clock,
  input logic                 reset,
  meta_write_arbiter_if.slave bus
);

  localparam int SRC_W = $clog2(N_IN);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAYS-1:0]  way_en;
    logic [TAG_W-1:0] tag;
  } req_t;

  logic             out_valid_q, out_valid_d;
  logic [SRC_W-1:0] out_src_q,   out_src_d;
  req_t             out_req_q,   out_req_d;
  logic [SRC_W-1:0] rr_ptr_q,    rr_ptr_d;

  logic [N_IN-1:0]  grant;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] start;
  logic             load;
  logic             any_valid;
  req_t             sel_req;

  // Fixed priority is the rotating selector with its start pinned at input 0.
  assign start = (RR == POLICY_RR) ? rr_ptr_q : '0;

  rr_prio_select #(
    .N  (N_IN),
    .SW (SRC_W)
  ) u_sel (
    .req       (bus.in_valid),
    .start     (start),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign any_valid = |bus.in_valid;
  // Register can take a new request when empty or emptying at this edge.
  assign load      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (reset || !load) ? '0 : grant;

  // AND-OR style payload mux driven by the one-hot grant.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant[i]) begin
        sel_req = '{idx:    bus.in_idx[i*IDX_W +: IDX_W],
                    way_en: bus.in_way_en[i*WAYS +: WAYS],
                    tag:    bus.in_tag[i*TAG_W +: TAG_W]};
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    out_req_d   = out_req_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = any_valid;
      // With no valid input the payload holds; it is don't-care while empty.
      if (any_valid) begin
        out_src_d = grant_idx;
        out_req_d = sel_req;
        // Pointer only moves on an input transfer, so a stalled winner keeps
        // its priority until it is accepted.
        if (RR == POLICY_RR) begin
          rr_ptr_d = (grant_idx == SRC_W'(N_IN - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      // NOTE: payload registers are reset too so the output bus comes up at a
      // defined all-zero value rather than whatever the flops powered up with.
      out_req_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      out_req_q   <= out_req_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_src    = out_src_q;
  assign bus.out_idx    = out_req_q.idx;
  assign bus.out_way_en = out_req_q.way_en;
  assign bus.out_tag    = out_req_q.tag;

endmodule

// File: tb/tb_meta_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_meta_write_arbiter
// Drives a fixed-priority and a round-robin instance with identical stimulus
// and compares both against a cycle-level reference model of the arbitration
// rules (search from a start index, wrap modulo N, first valid wins).
// -----------------------------------------------------------------------------
module tb_meta_write_arbiter;
  import meta_arb_pkg::*;

  localparam int N  = 4;
  localparam int IW = DEF_IDX_W;
  localparam int WW = DEF_WAYS;
  localparam int TW = DEF_TAG_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]  valid;
  logic          out_ready;
  logic [IW-1:0] d_idx [N];
  logic [WW-1:0] d_way [N];
  logic [TW-1:0] d_tag [N];

  logic [N*IW-1:0] p_idx;
  logic [N*WW-1:0] p_way;
  logic [N*TW-1:0] p_tag;

  always_comb begin
    p_idx = '0;
    p_way = '0;
    p_tag = '0;
    for (int i = 0; i < N; i++) begin
      p_idx[i*IW +: IW] = d_idx[i];
      p_way[i*WW +: WW] = d_way[i];
      p_tag[i*TW +: TW] = d_tag[i];
    end
  end

  meta_write_arbiter_if #(.N_IN(N), .IDX_W(IW), .WAYS(WW), .TAG_W(TW)) b0 ();
  meta_write_arbiter_if #(.N_IN(N), .IDX_W(IW), .WAYS(WW), .TAG_W(TW)) b1 ();

  assign b0.in_valid  = valid;
  assign b0.in_idx    = p_idx;
  assign b0.in_way_en = p_way;
  assign b0.in_tag    = p_tag;
  assign b0.out_ready = out_ready;
  assign b1.in_valid  = valid;
  assign b1.in_idx    = p_idx;
  assign b1.in_way_en = p_way;
  assign b1.in_tag    = p_tag;
  assign b1.out_ready = out_ready;

  meta_write_arbiter #(.N_IN(N), .IDX_W(IW), .WAYS(WW), .TAG_W(TW), .RR(POLICY_FIXED))
    dut0 (.clock(clk), .reset(reset), .bus(b0));
  meta_write_arbiter #(.N_IN(N), .IDX_W(IW), .WAYS(WW), .TAG_W(TW), .RR(POLICY_RR))
    dut1 (.clock(clk), .reset(reset), .bus(b1));

  // Observed outputs, index 0 = fixed priority, 1 = round-robin.
  logic [N-1:0]  o_rdy [2];
  logic          o_ov  [2];
  logic [1:0]    o_src [2];
  logic [IW-1:0] o_idx [2];
  logic [WW-1:0] o_way [2];
  logic [TW-1:0] o_tag [2];

  assign o_rdy[0] = b0.in_ready;   assign o_rdy[1] = b1.in_ready;
  assign o_ov[0]  = b0.out_valid;  assign o_ov[1]  = b1.out_valid;
  assign o_src[0] = b0.out_src;    assign o_src[1] = b1.out_src;
  assign o_idx[0] = b0.out_idx;    assign o_idx[1] = b1.out_idx;
  assign o_way[0] = b0.out_way_en; assign o_way[1] = b1.out_way_en;
  assign o_tag[0] = b0.out_tag;    assign o_tag[1] = b1.out_tag;

  int vectors = 0;
  int miscompares = 0;

  // Output transfers seen by the round-robin instance.
  int xfers1 = 0;
  always @(posedge clk) begin
    if (!reset && b1.out_valid && out_ready) xfers1++;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic      ov;
    int        src;
    meta_req_t req;
    int        rr;
  } model_t;

  model_t m [2];

  function automatic int pick(int p);
    int s = (p == 1) ? m[p].rr : 0;
    for (int k = 0; k < N; k++) begin
      int j = (s + k) % N;
      if (valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(int p);
    logic [N-1:0] r = '0;
    int g;
    if (reset) return r;
    if (m[p].ov && !out_ready) return r;
    g = pick(p);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        m[p].ov  = 1'b0;
        m[p].src = 0;
        m[p].req = '0;
        m[p].rr  = 0;
      end else if (!m[p].ov || out_ready) begin
        int g = pick(p);
        m[p].ov = (valid != '0);
        if (g >= 0) begin
          m[p].src        = g;
          m[p].req.idx    = d_idx[g];
          m[p].req.way_en = d_way[g];
          m[p].req.tag    = d_tag[g];
          if (p == 1) m[p].rr = (g + 1) % N;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      d_idx[i] = IW'($urandom);
      d_way[i] = WW'($urandom);
      d_tag[i] = TW'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid = '0;
    tick();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; valid = '1; out_ready = 1'b1;
    rand_payload();
    tick();
    tick();
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o_ov[p] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_out_valid[%0d] got=%b exp=0", p, o_ov[p]);
      end
      vectors++;
      if (o_rdy[p] !== '0) begin
        miscompares++;
        $display("FAIL reset_in_ready[%0d] got=%b exp=0000", p, o_rdy[p]);
      end
    end
    reset = 1'b0;
    #1;
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o_rdy[p] !== 4'b0001) begin
        miscompares++;
        $display("FAIL post_reset_ready[%0d] got=%b exp=0001", p, o_rdy[p]);
      end
    end
    tick();
    vectors++;
    if (o_ov[0] !== 1'b1 || o_src[0] !== 2'd0) begin
      miscompares++;
      $display("FAIL post_reset_load got ov=%b src=%0d exp ov=1 src=0", o_ov[0], o_src[0]);
    end
  endtask

  task automatic test_fixed_priority();
    valid = 4'b1010; out_ready = 1'b1;
    repeat (6) begin
      rand_payload();
      #1;
      vectors++;
      if (o_rdy[0] !== 4'b0010) begin
        miscompares++;
        $display("FAIL fixed_ready got=%b exp=0010", o_rdy[0]);
      end
      vectors++;
      if (o_rdy[1] !== exp_ready(1)) begin
        miscompares++;
        $display("FAIL fixed_rr_ready got=%b exp=%b", o_rdy[1], exp_ready(1));
      end
      tick();
      vectors++;
      if (o_ov[0] !== 1'b1 || o_src[0] !== 2'd1 || o_tag[0] !== m[0].req.tag) begin
        miscompares++;
        $display("FAIL fixed_out got ov=%b src=%0d tag=%h exp ov=1 src=1 tag=%h",
                 o_ov[0], o_src[0], o_tag[0], m[0].req.tag);
      end
    end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rand_payload();
      tick();
      vectors++;
      if (o_ov[1] !== 1'b1 || o_src[1] !== 2'(k % N)) begin
        miscompares++;
        $display("FAIL rr_src[%0d] got ov=%b src=%0d exp ov=1 src=%0d", k, o_ov[1], o_src[1], k % N);
      end
      vectors++;
      if (dut1.rr_ptr_q !== 2'((k + 1) % N)) begin
        miscompares++;
        $display("FAIL rr_ptr[%0d] got=%0d exp=%0d", k, dut1.rr_ptr_q, (k + 1) % N);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [TW-1:0] t0, t3;
    do_reset();
    valid = 4'b0100; out_ready = 1'b1;
    rand_payload();
    d_tag[2] = 20'hABCDE;
    tick();
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o_tag[p] !== 20'hABCDE || o_src[p] !== 2'd2) begin
        miscompares++;
        $display("FAIL bp_load[%0d] got tag=%h src=%0d exp tag=abcde src=2", p, o_tag[p], o_src[p]);
      end
    end
    valid = '1; out_ready = 1'b0;
    repeat (5) begin
      rand_payload();
      #1;
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (o_rdy[p] !== '0) begin
          miscompares++;
          $display("FAIL bp_ready[%0d] got=%b exp=0000", p, o_rdy[p]);
        end
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (o_ov[p] !== 1'b1 || o_tag[p] !== 20'hABCDE) begin
          miscompares++;
          $display("FAIL bp_hold[%0d] got ov=%b tag=%h exp ov=1 tag=abcde", p, o_ov[p], o_tag[p]);
        end
      end
      vectors++;
      if (dut1.rr_ptr_q !== 2'd3) begin
        miscompares++;
        $display("FAIL bp_rr_ptr got=%0d exp=3", dut1.rr_ptr_q);
      end
    end
    out_ready = 1'b1;
    rand_payload();
    t0 = d_tag[0];
    t3 = d_tag[3];
    #1;
    vectors++;
    if (o_rdy[0] !== 4'b0001 || o_rdy[1] !== 4'b1000) begin
      miscompares++;
      $display("FAIL bp_release_ready got fixed=%b rr=%b exp fixed=0001 rr=1000", o_rdy[0], o_rdy[1]);
    end
    tick();
    vectors++;
    if (o_ov[0] !== 1'b1 || o_src[0] !== 2'd0 || o_tag[0] !== t0) begin
      miscompares++;
      $display("FAIL bp_refill_fixed got ov=%b src=%0d tag=%h exp ov=1 src=0 tag=%h",
               o_ov[0], o_src[0], o_tag[0], t0);
    end
    vectors++;
    if (o_ov[1] !== 1'b1 || o_src[1] !== 2'd3 || o_tag[1] !== t3) begin
      miscompares++;
      $display("FAIL bp_refill_rr got ov=%b src=%0d tag=%h exp ov=1 src=3 tag=%h",
               o_ov[1], o_src[1], o_tag[1], t3);
    end
  endtask

  task automatic test_drain();
    do_reset();
    valid = 4'b0010; out_ready = 1'b1;
    rand_payload();
    tick();
    valid = '0;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (o_ov[p] !== (c == 0)) begin
          miscompares++;
          $display("FAIL drain[%0d] cycle %0d got ov=%b exp=%b", p, c, o_ov[p], c == 0);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int x0;
    do_reset();
    valid = 4'b0001; out_ready = 1'b1;
    rand_payload();
    tick();
    valid = '1; out_ready = 1'b0;
    tick();
    vectors++;
    if (o_ov[0] !== 1'b1 || o_ov[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_held got ov=%b%b exp=11", o_ov[0], o_ov[1]);
    end
    x0 = xfers1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    valid = '0;
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (o_ov[p] !== 1'b0 || o_src[p] !== 2'd0 || o_tag[p] !== '0) begin
        miscompares++;
        $display("FAIL mid_reset[%0d] got ov=%b src=%0d tag=%h exp 0/0/0", p, o_ov[p], o_src[p], o_tag[p]);
      end
    end
    vectors++;
    if (dut1.rr_ptr_q !== 2'd0) begin
      miscompares++;
      $display("FAIL mid_rr_ptr got=%0d exp=0", dut1.rr_ptr_q);
    end
    vectors++;
    if (xfers1 !== x0) begin
      miscompares++;
      $display("FAIL mid_no_xfer got=%0d exp=%0d", xfers1, x0);
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (400) begin
      valid     = N'($urandom);
      out_ready = ($urandom % 4) != 0;
      reset     = ($urandom % 50) == 0;
      rand_payload();
      #1;
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (o_rdy[p] !== exp_ready(p)) begin
          miscompares++;
          $display("FAIL rnd_ready[%0d] got=%b exp=%b", p, o_rdy[p], exp_ready(p));
        end
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (o_ov[p] !== m[p].ov) begin
          miscompares++;
          $display("FAIL rnd_valid[%0d] got=%b exp=%b", p, o_ov[p], m[p].ov);
        end
        if (m[p].ov) begin
          vectors++;
          if (o_src[p] !== 2'(m[p].src) || o_idx[p] !== m[p].req.idx ||
              o_way[p] !== m[p].req.way_en || o_tag[p] !== m[p].req.tag) begin
            miscompares++;
            $display("FAIL rnd_data[%0d] got src=%0d idx=%h way=%h tag=%h exp src=%0d idx=%h way=%h tag=%h",
                     p, o_src[p], o_idx[p], o_way[p], o_tag[p],
                     m[p].src, m[p].req.idx, m[p].req.way_en, m[p].req.tag);
          end
        end
      end
      vectors++;
      if (dut1.rr_ptr_q !== 2'(m[1].rr)) begin
        miscompares++;
        $display("FAIL rnd_rr_ptr got=%0d exp=%0d", dut1.rr_ptr_q, m[1].rr);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    valid = '0;
    out_ready = 1'b0;
    rand_payload();
    for (int p = 0; p < 2; p++) begin
      m[p].ov  = 1'b0;
      m[p].src = 0;
      m[p].req = '0;
      m[p].rr  = 0;
    end
    @(negedge clk);
    test_reset();
    test_fixed_priority();
    test_rr_fairness();
    test_back_pressure();
    test_drain();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
